// File: rtl/mtime_multi.sv
// 64-bit machine timer with NUM_CMP compare channels (level or periodic auto-reload) on a word-addressed bus.
// Reads are combinational, writes land on the next clk; the bus never stalls.
module mtime_multi #(
  parameter int  CLK_PERIOD = 10,
  parameter int  TICK_NS    = 1000,
  parameter int  NUM_CMP    = 4,
  localparam int ADDR_W     = $clog2(4 + 4*NUM_CMP)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        wr_data,
  input  logic [3:0]         wr_strobe,
  output logic [31:0]        rd_data,
  output logic [63:0]        time_rd_data,
  output logic [NUM_CMP-1:0] irq,
  output logic               interrupt
);

  localparam int CYC = TICK_NS / CLK_PERIOD;
  localparam int PW  = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CYC - 1);

  logic [63:0]        mtime_q, mtime_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               en_q, en_d;
  logic               tick;
  logic [63:0]        cmp_q    [NUM_CMP];
  logic [63:0]        cmp_d    [NUM_CMP];
  logic [31:0]        period_q [NUM_CMP];
  logic [31:0]        period_d [NUM_CMP];
  logic [NUM_CMP-1:0] periodic_q, periodic_d, ie_q, ie_d, pend_q, pend_d;
  logic [NUM_CMP-1:0] hit, pend, w1c;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < NUM_CMP; g++) begin : g_hit
    assign hit[g] = (mtime_q >= cmp_q[g]);
  end

  // Periodic channels report the sticky flag; level channels report the live compare.
  assign pend         = (periodic_q & pend_q) | (~periodic_q & hit);
  assign irq          = ie_q & pend;
  assign interrupt    = |irq;
  assign time_rd_data = mtime_q;

  always_comb begin
    tick    = en_q && (presc_q == PMAX);
    presc_d = presc_q;
    if (en_q) presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_en && addr == ADDR_W'(0))
      mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wr_data, wr_strobe)};
    if (wr_en && addr == ADDR_W'(1))
      mtime_d = {merge(mtime_q[63:32], wr_data, wr_strobe), mtime_q[31:0]};
    en_d     = (wr_en && addr == ADDR_W'(2) && wr_strobe[0]) ? wr_data[0] : en_q;
    shadow_d = (rd_en && addr == ADDR_W'(0)) ? mtime_q[63:32] : shadow_q;
    w1c      = (wr_en && addr == ADDR_W'(3) && wr_strobe[0]) ? wr_data[NUM_CMP-1:0] : '0;

    periodic_d = periodic_q;
    ie_d       = ie_q;
    pend_d     = pend_q;
    for (int i = 0; i < NUM_CMP; i++) begin
      cmp_d[i]    = cmp_q[i];
      period_d[i] = period_q[i];
      if (wr_en && addr == ADDR_W'(4 + 4*i))
        cmp_d[i] = {cmp_q[i][63:32], merge(cmp_q[i][31:0], wr_data, wr_strobe)};
      else if (wr_en && addr == ADDR_W'(5 + 4*i))
        cmp_d[i] = {merge(cmp_q[i][63:32], wr_data, wr_strobe), cmp_q[i][31:0]};
      else if (periodic_q[i] && hit[i])
        cmp_d[i] = cmp_q[i] + {32'd0, period_q[i]};
      if (wr_en && addr == ADDR_W'(6 + 4*i))
        period_d[i] = merge(period_q[i], wr_data, wr_strobe);
      if (w1c[i]) pend_d[i] = 1'b0;
      if (periodic_q[i] && hit[i]) pend_d[i] = 1'b1;
      // A mode switch starts the channel with a clean sticky flag.
      if (wr_en && addr == ADDR_W'(7 + 4*i) && wr_strobe[0]) begin
        periodic_d[i] = wr_data[0];
        ie_d[i]       = wr_data[1];
        if (wr_data[0] != periodic_q[i]) pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      if (addr == ADDR_W'(0)) rd_data = mtime_q[31:0];
      if (addr == ADDR_W'(1)) rd_data = shadow_q;
      if (addr == ADDR_W'(2)) rd_data = {31'd0, en_q};
      if (addr == ADDR_W'(3)) rd_data = 32'(pend);
      for (int i = 0; i < NUM_CMP; i++) begin
        if (addr == ADDR_W'(4 + 4*i)) rd_data = cmp_q[i][31:0];
        if (addr == ADDR_W'(5 + 4*i)) rd_data = cmp_q[i][63:32];
        if (addr == ADDR_W'(6 + 4*i)) rd_data = period_q[i];
        if (addr == ADDR_W'(7 + 4*i)) rd_data = {30'd0, ie_q[i], periodic_q[i]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      shadow_q   <= '0;
      presc_q    <= '0;
      en_q       <= 1'b1;
      periodic_q <= '0;
      ie_q       <= '0;
      pend_q     <= '0;
      for (int i = 0; i < NUM_CMP; i++) begin
        cmp_q[i]    <= '1;
        period_q[i] <= '0;
      end
    end else begin
      mtime_q    <= mtime_d;
      shadow_q   <= shadow_d;
      presc_q    <= presc_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      ie_q       <= ie_d;
      pend_q     <= pend_d;
      for (int i = 0; i < NUM_CMP; i++) begin
        cmp_q[i]    <= cmp_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mtime_multi.sv
// Self-checking bench for mtime_multi: CLK_PERIOD=10, TICK_NS=1000 (100 clocks per mtime tick).
module tb_mtime_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strobe = '0;
  logic [31:0] rd_data;
  logic [63:0] time_rd_data;
  logic [3:0]  irq;
  logic        interrupt;

  int nchecks = 0;
  int nerrs   = 0;
  logic [63:0] exp_q[$];

  mtime_multi #(.CLK_PERIOD(10), .TICK_NS(1000), .NUM_CMP(4)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
    .time_rd_data(time_rd_data), .irq(irq), .interrupt(interrupt));

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 2ms", $time);
    $fatal(1);
  end

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    wr_en = 1'b1; addr = a; wr_data = d; wr_strobe = s;
    @(posedge clk);
    #1 wr_en = 1'b0; wr_strobe = '0;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_en = 1'b1; addr = a;
    #1 d = rd_data;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic wait_time(input logic [63:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (time_rd_data == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    logic [63:0] e;
    #2 rst_n = 1'b0;
    #1;
    nchecks++; if (time_rd_data !== 64'd0) begin nerrs++; $display("FAIL reset_mtime got %0h required 0", time_rd_data); end
    nchecks++; if ({irq, interrupt} !== 5'd0) begin nerrs++; $display("FAIL reset_irq got %b required 0", {irq, interrupt}); end
    nchecks++; if (rd_data !== 32'd0) begin nerrs++; $display("FAIL reset_rd_idle got %0h required 0", rd_data); end
    rd_en = 1'b1; addr = 5'd2; exp_q.push_back(64'd1); #1;
    e = exp_q.pop_front();
    nchecks++; if (64'(rd_data) !== e) begin nerrs++; $display("FAIL reset_ctrl got %0h required %0h", rd_data, e); end
    addr = 5'd4; exp_q.push_back(64'hFFFF_FFFF); #1;
    e = exp_q.pop_front();
    nchecks++; if (64'(rd_data) !== e) begin nerrs++; $display("FAIL reset_cmp0_lo got %0h required %0h", rd_data, e); end
    rd_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    exp_q.push_back(64'd10);
    repeat (1000) @(posedge clk);
    #1 e = exp_q.pop_front();
    nchecks++; if (time_rd_data !== e) begin nerrs++; $display("FAIL idle_mtime got %0d required %0d", time_rd_data, e); end
    nchecks++; if (irq !== 4'd0) begin nerrs++; $display("FAIL idle_irq got %b required 0000", irq); end
  endtask

  task automatic test_level;
    bit ok;
    logic prev_irq;
    logic [31:0] d;
    logic [63:0] e;
    do_write(5'd2, 32'd0, 4'hF);
    do_write(5'd0, 32'd0, 4'hF);
    do_write(5'd1, 32'd0, 4'hF);
    do_write(5'd5, 32'd0, 4'hF);
    do_write(5'd4, 32'd5, 4'hF);
    do_write(5'd7, 32'd2, 4'hF);
    do_write(5'd2, 32'd1, 4'hF);
    prev_irq = irq[0];
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      if (time_rd_data == 64'd5) begin ok = 1'b1; break; end
      prev_irq = irq[0];
    end
    nchecks++; if (!ok) begin nerrs++; $display("FAIL level_wait got timeout required mtime=5"); end
    nchecks++; if (prev_irq !== 1'b0) begin nerrs++; $display("FAIL level_before got %b required 0", prev_irq); end
    nchecks++; if (irq[0] !== 1'b1 || interrupt !== 1'b1) begin nerrs++; $display("FAIL level_rise got irq0=%b int=%b required 1/1", irq[0], interrupt); end
    do_write(5'd3, 32'd1, 4'hF);
    nchecks++; if (irq[0] !== 1'b1) begin nerrs++; $display("FAIL level_w1c got %b required 1", irq[0]); end
    exp_q.push_back(64'd1);
    do_read(5'd3, d);
    e = exp_q.pop_front();
    nchecks++; if (64'(d) !== e) begin nerrs++; $display("FAIL level_status got %0h required %0h", d, e); end
    do_write(5'd7, 32'd0, 4'hF);
    do_write(5'd5, 32'hFFFF_FFFF, 4'hF);
    nchecks++; if (interrupt !== 1'b0) begin nerrs++; $display("FAIL level_off got %b required 0", interrupt); end
  endtask

  task automatic test_periodic;
    bit ok;
    logic [31:0] d;
    logic [63:0] e;
    logic [63:0] match [3];
    match[0] = 64'd3; match[1] = 64'd7; match[2] = 64'd11;
    do_write(5'd2, 32'd0, 4'hF);
    do_write(5'd0, 32'd0, 4'hF);
    do_write(5'd1, 32'd0, 4'hF);
    do_write(5'd11, 32'd3, 4'hF);
    do_write(5'd10, 32'd4, 4'hF);
    do_write(5'd9, 32'd0, 4'hF);
    do_write(5'd8, 32'd3, 4'hF);
    do_write(5'd2, 32'd1, 4'hF);
    for (int k = 0; k < 3; k++) begin
      wait_time(match[k], 500, ok);
      nchecks++; if (!ok) begin nerrs++; $display("FAIL per_wait%0d got timeout required mtime=%0d", k, match[k]); end
      @(posedge clk); #1;
      nchecks++; if (irq !== 4'b0010) begin nerrs++; $display("FAIL per_irq%0d got %b required 0010", k, irq); end
      exp_q.push_back(match[k] + 64'd4);
      exp_q.push_back(64'd2);
      do_read(5'd8, d);
      e = exp_q.pop_front();
      nchecks++; if (64'(d) !== e) begin nerrs++; $display("FAIL per_cmp%0d got %0d required %0d", k, d, e); end
      do_read(5'd3, d);
      e = exp_q.pop_front();
      nchecks++; if (64'(d) !== e) begin nerrs++; $display("FAIL per_status%0d got %0h required %0h", k, d, e); end
      do_write(5'd3, 32'd2, 4'hF);
      nchecks++; if (irq[1] !== 1'b0) begin nerrs++; $display("FAIL per_w1c%0d got %b required 0", k, irq[1]); end
    end
    do_write(5'd11, 32'd0, 4'hF);
  endtask

  task automatic test_shadow;
    bit ok;
    logic [31:0] d;
    logic [63:0] e;
    do_write(5'd2, 32'd0, 4'hF);
    do_write(5'd0, 32'hFFFF_FFFF, 4'hF);
    do_write(5'd1, 32'd0, 4'hF);
    do_write(5'd2, 32'd1, 4'hF);
    wait_time(64'h1_0000_0000, 300, ok);
    nchecks++; if (!ok) begin nerrs++; $display("FAIL shadow_wait got timeout required carry"); end
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd1);
    do_read(5'd0, d);
    e = exp_q.pop_front();
    nchecks++; if (64'(d) !== e) begin nerrs++; $display("FAIL shadow_lo got %0h required %0h", d, e); end
    do_read(5'd1, d);
    e = exp_q.pop_front();
    nchecks++; if (64'(d) !== e) begin nerrs++; $display("FAIL shadow_hi got %0h required %0h", d, e); end
    // Carry lands between the LO and HI reads; HI must still be the pre-carry half.
    do_write(5'd2, 32'd0, 4'hF);
    do_write(5'd0, 32'hFFFF_FFFE, 4'hF);
    do_write(5'd1, 32'd0, 4'hF);
    do_write(5'd2, 32'd1, 4'hF);
    wait_time(64'hFFFF_FFFF, 300, ok);
    nchecks++; if (!ok) begin nerrs++; $display("FAIL shadow_wait2 got timeout required FFFFFFFF"); end
    exp_q.push_back(64'hFFFF_FFFF);
    exp_q.push_back(64'd0);
    do_read(5'd0, d);
    e = exp_q.pop_front();
    nchecks++; if (64'(d) !== e) begin nerrs++; $display("FAIL shadow_lo2 got %0h required %0h", d, e); end
    wait_time(64'h1_0000_0000, 300, ok);
    nchecks++; if (!ok) begin nerrs++; $display("FAIL shadow_wait3 got timeout required carry"); end
    do_read(5'd1, d);
    e = exp_q.pop_front();
    nchecks++; if (64'(d) !== e) begin nerrs++; $display("FAIL shadow_hi2 got %0h required %0h", d, e); end
  endtask

  task automatic test_strobe;
    logic [31:0] d;
    logic [63:0] e;
    do_write(5'd14, 32'h1122_3344, 4'hF);
    do_write(5'd14, 32'hAABB_CCDD, 4'b0010);
    do_write(5'd31, 32'hDEAD_BEEF, 4'hF);
    exp_q.push_back(64'h1122_CC44);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    do_read(5'd14, d);
    e = exp_q.pop_front();
    nchecks++; if (64'(d) !== e) begin nerrs++; $display("FAIL strobe_period2 got %0h required %0h", d, e); end
    do_read(5'd31, d);
    e = exp_q.pop_front();
    nchecks++; if (64'(d) !== e) begin nerrs++; $display("FAIL unmapped31 got %0h required %0h", d, e); end
    do_read(5'd20, d);
    e = exp_q.pop_front();
    nchecks++; if (64'(d) !== e) begin nerrs++; $display("FAIL unmapped20 got %0h required %0h", d, e); end
  endtask

  task automatic test_enable_reset;
    logic [63:0] t0;
    logic [31:0] d;
    logic [63:0] e;
    int n;
    t0 = time_rd_data;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (time_rd_data != t0) break;
    end
    // Prescaler is 0 here; freezing on the next edge leaves it at 1.
    do_write(5'd2, 32'd0, 4'hF);
    t0 = time_rd_data;
    exp_q.push_back(t0);
    repeat (500) @(posedge clk);
    #1 e = exp_q.pop_front();
    nchecks++; if (time_rd_data !== e) begin nerrs++; $display("FAIL en_frozen got %0h required %0h", time_rd_data, e); end
    do_write(5'd2, 32'd1, 4'hF);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      n++;
      if (time_rd_data != t0) break;
    end
    nchecks++; if (n !== 99) begin nerrs++; $display("FAIL en_phase got %0d cycles required 99", n); end
    nchecks++; if (time_rd_data !== t0 + 64'd1) begin nerrs++; $display("FAIL en_resume got %0h required %0h", time_rd_data, t0 + 64'd1); end
    do_write(5'd6, 32'd123, 4'hF);
    do_write(5'd5, 32'd0, 4'hF);
    do_write(5'd4, 32'd0, 4'hF);
    do_write(5'd7, 32'd2, 4'hF);
    nchecks++; if (interrupt !== 1'b1) begin nerrs++; $display("FAIL pre_reset_irq got %b required 1", interrupt); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    nchecks++; if (time_rd_data !== 64'd0 || irq !== 4'd0 || interrupt !== 1'b0) begin
      nerrs++; $display("FAIL async_reset got mtime=%0h irq=%b int=%b required 0/0/0", time_rd_data, irq, interrupt);
    end
    rd_en = 1'b1; addr = 5'd6; #1;
    nchecks++; if (rd_data !== 32'd0) begin nerrs++; $display("FAIL async_reset_period got %0h required 0", rd_data); end
    addr = 5'd5; #1;
    nchecks++; if (rd_data !== 32'hFFFF_FFFF) begin nerrs++; $display("FAIL async_reset_cmp_hi got %0h required ffffffff", rd_data); end
    addr = 5'd7; #1;
    nchecks++; if (rd_data !== 32'd0) begin nerrs++; $display("FAIL async_reset_cctrl got %0h required 0", rd_data); end
    rd_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset;
    test_level;
    test_periodic;
    test_shadow;
    test_strobe;
    test_enable_reset;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
